// File: rtl/keypad_emulator.sv
`default_nettype none
// keypad_emulator: 3x3 matrix keypad model answering scanner row strobes (rev 1.0).
// Optional KEYPAD_EMULATOR_BOUNCE_EN adds contact bounce on the leading edge of each press.
module keypad_emulator #(
  parameter int unsigned HOLD_TICKS = 20,
  parameter int unsigned GAP_TICKS  = 10
) (
  input  logic       clk_100Hz,
  input  logic       reset,
  input  logic       cmd_valid,
  input  logic [3:0] cmd_key,
  output logic       cmd_ready,
  input  logic [3:0] keypadRow,
  output logic [3:0] keypadCol,
  output logic       busy,
  output logic       done,
  output logic       err
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PRESS = 2'd1,
    S_GAP   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [7:0] C_HOLD_LOAD = 8'(HOLD_TICKS - 1);
  localparam logic [7:0] C_GAP_LOAD  = 8'(GAP_TICKS - 1);

  state_t     state_q, state_d;
  logic [7:0] tick_cnt_q, tick_cnt_d;
  logic       press_active_q, press_active_d;
  logic [3:0] row_pat_q, row_pat_d;
  logic [3:0] col_pat_q, col_pat_d;
  logic       err_q, err_d;

  logic [3:0] w_row_pat;
  logic [3:0] w_col_pat;
  logic       w_key_ok;
  logic       w_press_start;
  logic       w_press_next;

  assign w_key_ok = (cmd_key <= 4'd8);

  always_comb begin
    w_row_pat = 4'b1111;
    w_col_pat = 4'b1111;
    case (cmd_key)
      4'd0, 4'd1, 4'd2: w_row_pat = 4'b0111;
      4'd3, 4'd4, 4'd5: w_row_pat = 4'b1011;
      4'd6, 4'd7, 4'd8: w_row_pat = 4'b1101;
      default:          w_row_pat = 4'b1111;
    endcase
    case (cmd_key)
      4'd0, 4'd3, 4'd6: w_col_pat = 4'b0111;
      4'd1, 4'd4, 4'd7: w_col_pat = 4'b1011;
      4'd2, 4'd5, 4'd8: w_col_pat = 4'b1101;
      default:          w_col_pat = 4'b1111;
    endcase
  end

`ifdef KEYPAD_EMULATOR_BOUNCE_EN
  logic [7:0] w_press_idx;
  // Index of the PRESS cycle that follows this edge; contact opens on index 0 and 2.
  assign w_press_idx   = 8'(HOLD_TICKS) - tick_cnt_q;
  assign w_press_start = 1'b0;
  assign w_press_next  = (w_press_idx != 8'd2);
`else
  assign w_press_start = 1'b1;
  assign w_press_next  = 1'b1;
`endif

  always_comb begin
    state_d        = state_q;
    tick_cnt_d     = tick_cnt_q;
    press_active_d = press_active_q;
    row_pat_d      = row_pat_q;
    col_pat_d      = col_pat_q;
    err_d          = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          if (w_key_ok) begin
            row_pat_d      = w_row_pat;
            col_pat_d      = w_col_pat;
            press_active_d = w_press_start;
            tick_cnt_d     = C_HOLD_LOAD;
            state_d        = S_PRESS;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_PRESS: begin
        if (tick_cnt_q == 8'd0) begin
          press_active_d = 1'b0;
          tick_cnt_d     = C_GAP_LOAD;
          state_d        = S_GAP;
        end else begin
          press_active_d = w_press_next;
          tick_cnt_d     = tick_cnt_q - 8'd1;
        end
      end
      S_GAP: begin
        if (tick_cnt_q == 8'd0) begin
          state_d = S_DONE;
        end else begin
          tick_cnt_d = tick_cnt_q - 8'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_100Hz or negedge reset) begin
    if (!reset) begin
      state_q        <= S_IDLE;
      tick_cnt_q     <= 8'd0;
      press_active_q <= 1'b0;
      row_pat_q      <= 4'b1111;
      col_pat_q      <= 4'b1111;
      err_q          <= 1'b0;
    end else begin
      state_q        <= state_d;
      tick_cnt_q     <= tick_cnt_d;
      press_active_q <= press_active_d;
      row_pat_q      <= row_pat_d;
      col_pat_q      <= col_pat_d;
      err_q          <= err_d;
    end
  end

  // Zero-latency column answer so the scanner samples a consistent row/column pair.
  assign keypadCol = (press_active_q && (keypadRow == row_pat_q)) ? col_pat_q : 4'b1111;
  assign cmd_ready = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign err       = err_q;

endmodule
`default_nettype wire

// File: tb/tb_keypad_emulator.sv
`default_nettype none
// tb_keypad_emulator: directed self-checking bench for keypad_emulator (rev 1.0).
module tb_keypad_emulator;

  logic       clk_100Hz = 1'b0;
  logic       reset     = 1'b0;
  logic       cmd_valid = 1'b0;
  logic [3:0] cmd_key   = 4'd0;
  logic       cmd_ready;
  logic [3:0] keypadRow = 4'b1111;
  logic [3:0] keypadCol;
  logic       busy;
  logic       done;
  logic       err;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int n_acc  = 0;
  int acc_cyc [0:7];
  logic [3:0] rows [0:3];
  logic [3:0] bounce_exp [0:4];
  bit seen_done;
  bit timed_out;

  keypad_emulator #(.HOLD_TICKS(20), .GAP_TICKS(10)) dut (
    .clk_100Hz (clk_100Hz),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_key   (cmd_key),
    .cmd_ready (cmd_ready),
    .keypadRow (keypadRow),
    .keypadCol (keypadCol),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clk_100Hz = ~clk_100Hz;

  always @(posedge clk_100Hz) begin
    cyc = cyc + 1;
    if (reset && cmd_valid && cmd_ready && n_acc < 8) begin
      acc_cyc[n_acc] = cyc;
      n_acc = n_acc + 1;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks = checks + 1;
    assert (obs === exp) else begin
      errors = errors + 1;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Sweep every row strobe within the current low clock phase.
  task automatic chk_rows(input string tag, input logic [3:0] hit_row, input logic [3:0] hit_col);
    for (int r = 0; r < 4; r++) begin
      keypadRow = rows[r];
      #1;
      chk(tag, {4'h0, keypadCol}, {4'h0, (rows[r] == hit_row) ? hit_col : 4'b1111});
    end
  endtask

  task automatic send_key(input logic [3:0] k);
    cmd_valid = 1'b1;
    cmd_key   = k;
    @(negedge clk_100Hz);
    cmd_valid = 1'b0;
  endtask

  initial begin
    rows[0] = 4'b1110; rows[1] = 4'b1101; rows[2] = 4'b1011; rows[3] = 4'b0111;
`ifdef KEYPAD_EMULATOR_BOUNCE_EN
    bounce_exp[0] = 4'b1111; bounce_exp[1] = 4'b1101; bounce_exp[2] = 4'b1111;
    bounce_exp[3] = 4'b1101; bounce_exp[4] = 4'b1101;
`else
    bounce_exp[0] = 4'b1101; bounce_exp[1] = 4'b1101; bounce_exp[2] = 4'b1101;
    bounce_exp[3] = 4'b1101; bounce_exp[4] = 4'b1101;
`endif

    // Reset state
    repeat (2) @(negedge clk_100Hz);
    chk_rows("reset_col", 4'b0000, 4'b1111);
    keypadRow = 4'b1111; #1;
    chk("reset_col_idle_row", {4'h0, keypadCol}, 8'h0F);
    chk("reset_ready", {7'h0, cmd_ready}, 8'h01);
    chk("reset_busy",  {7'h0, busy},      8'h00);
    chk("reset_done",  {7'h0, done},      8'h00);
    chk("reset_err",   {7'h0, err},       8'h00);
    reset = 1'b1;
    @(negedge clk_100Hz);

    // Key 4: full press/gap/done timeline, index i = cycle after edge accept+i
    send_key(4'd4);
    for (int i = 0; i < 32; i++) begin
      chk_rows("k4_col", 4'b1011, (i < 20) ? 4'b1011 : 4'b1111);
      chk("k4_busy",  {7'h0, busy},      {7'h0, (i <= 30)});
      chk("k4_done",  {7'h0, done},      {7'h0, (i == 30)});
      chk("k4_ready", {7'h0, cmd_ready}, {7'h0, (i == 31)});
      chk("k4_err",   {7'h0, err},       8'h00);
      @(negedge clk_100Hz);
    end

    // Key 0 then key 8 with cmd_valid held
    n_acc = 0;
    cmd_valid = 1'b1;
    cmd_key   = 4'd0;
    @(negedge clk_100Hz);
    cmd_key = 4'd8;
    chk("k0_accepted", n_acc[7:0], 8'd1);
    for (int i = 0; i < 6; i++) @(negedge clk_100Hz);
    chk_rows("k0_col", 4'b0111, 4'b0111);
    timed_out = 1'b1;
    for (int w = 0; w < 100; w++) begin
      @(negedge clk_100Hz);
      if (n_acc >= 2) begin
        timed_out = 1'b0;
        break;
      end
    end
    cmd_valid = 1'b0;
    chk("k8_accept_timeout", {7'h0, timed_out}, 8'h00);
    chk("b2b_spacing", 8'(acc_cyc[1] - acc_cyc[0]), 8'd32);
    for (int i = 0; i < 6; i++) @(negedge clk_100Hz);
    chk_rows("k8_col", 4'b1101, 4'b1101);
    for (int i = 0; i < 30; i++) @(negedge clk_100Hz);
    chk("k8_back_idle", {7'h0, cmd_ready}, 8'h01);

    // Invalid key 9
    send_key(4'd9);
    chk("k9_err",   {7'h0, err},       8'h01);
    chk("k9_busy",  {7'h0, busy},      8'h00);
    chk("k9_ready", {7'h0, cmd_ready}, 8'h01);
    chk_rows("k9_col", 4'b0000, 4'b1111);
    @(negedge clk_100Hz);
    chk("k9_err_pulse", {7'h0, err}, 8'h00);
    chk("k9_done",      {7'h0, done}, 8'h00);

    // Asynchronous reset at PRESS cycle 5
    send_key(4'd4);
    for (int i = 0; i < 5; i++) @(negedge clk_100Hz);
    keypadRow = 4'b1011; #1;
    chk("rst_pre_col", {4'h0, keypadCol}, 8'h0B);
    reset = 1'b0; #1;
    chk("rst_async_col", {4'h0, keypadCol}, 8'h0F);
    chk("rst_ready",     {7'h0, cmd_ready}, 8'h01);
    chk("rst_busy",      {7'h0, busy},      8'h00);
    #1 reset = 1'b1;
    seen_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk_100Hz);
      if (done || busy) seen_done = 1'b1;
    end
    chk("rst_no_done", {7'h0, seen_done}, 8'h00);
    chk("rst_col_after", {4'h0, keypadCol}, 8'h0F);

    // Key 2 on constant row 0111: leading-edge shape and end of press
    keypadRow = 4'b0111;
    send_key(4'd2);
    for (int i = 0; i < 21; i++) begin
      #1;
      if (i < 5)
        chk("k2_lead_col", {4'h0, keypadCol}, {4'h0, bounce_exp[i]});
      else
        chk("k2_col", {4'h0, keypadCol}, {4'h0, (i < 20) ? 4'b1101 : 4'b1111});
      @(negedge clk_100Hz);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
